// File: rtl/mc_router_xbar_if.sv
// Port bundle of the multicast crossbar: per-port flit buses with valid/ready
// on both the injection and ejection sides.
interface mc_router_xbar_if #(
  parameter int NUM_PORTS = 5,
  parameter int DATASIZE  = 30
);
  logic [NUM_PORTS*DATASIZE-1:0] in_data;
  logic [NUM_PORTS-1:0]          in_valid;
  logic [NUM_PORTS-1:0]          in_ready;
  logic [NUM_PORTS*DATASIZE-1:0] out_data;
  logic [NUM_PORTS-1:0]          out_valid;
  logic [NUM_PORTS-1:0]          out_ready;
  logic [NUM_PORTS-1:0]          drop_pulse;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, drop_pulse
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, drop_pulse
  );
endinterface

// File: rtl/mc_router_xbar.sv
// Input-buffered NUM_PORTS crossbar with mask-routed multicast, partial fork
// service, per-output round-robin arbitration and registered outputs.
module mc_router_xbar #(
  parameter int NUM_PORTS = 5,
  parameter int DATASIZE  = 30,
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 2
) (
  input  logic            clk,
  input  logic            rst,
  mc_router_xbar_if.slave bus
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef logic [NUM_PORTS-1:0] mask_t;
  typedef logic [DATASIZE-1:0]  flit_t;

  flit_t          mem       [NUM_PORTS][DEPTH];
  logic [WIDTH:0] wr_ptr    [NUM_PORTS];
  logic [WIDTH:0] rd_ptr    [NUM_PORTS];
  mask_t          pend      [NUM_PORTS];
  mask_t          pend_load;
  logic [PW-1:0]  rr_ptr    [NUM_PORTS];

  mask_t          full, empty, push, pop, drop, grant_any;
  flit_t          head      [NUM_PORTS];
  mask_t          req_mask  [NUM_PORTS];  // outputs still owed a copy, per input
  mask_t          won       [NUM_PORTS];  // outputs granted this cycle, per input
  logic [PW-1:0]  grant_idx [NUM_PORTS];

  // A freshly exposed head competes with its full header mask in the same cycle.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      empty[p] = (wr_ptr[p] == rd_ptr[p]);
      full[p]  = (wr_ptr[p][WIDTH] != rd_ptr[p][WIDTH]) &&
                 (wr_ptr[p][WIDTH-1:0] == rd_ptr[p][WIDTH-1:0]);
      push[p]  = bus.in_valid[p] && !full[p];
      head[p]  = mem[p][rd_ptr[p][WIDTH-1:0]];
      if (empty[p])          req_mask[p] = '0;
      else if (pend_load[p]) req_mask[p] = head[p][DATASIZE-1 -: NUM_PORTS];
      else                   req_mask[p] = pend[p];
    end
  end

  assign bus.in_ready = ~full;

  // NOTE: every output of this block gets a default before any conditional
  // assignment, so no path leaves a signal holding its old value (no latch).
  always_comb begin
    logic [PW:0]   cand;
    logic [PW-1:0] sel;
    cand      = '0;
    sel       = '0;
    grant_any = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      won[i]       = '0;
      grant_idx[i] = '0;
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (!bus.out_valid[o] || bus.out_ready[o]) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          cand = {1'b0, rr_ptr[o]} + (PW+1)'(k);
          if (cand >= (PW+1)'(NUM_PORTS)) cand = cand - (PW+1)'(NUM_PORTS);
          sel = cand[PW-1:0];
          if (!grant_any[o] && req_mask[sel][o]) begin
            grant_any[o]  = 1'b1;
            grant_idx[o]  = sel;
            won[sel][o]   = 1'b1;
          end
        end
      end
    end
  end

  // A head retires once nothing is left owed; a zero mask retires immediately.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      pop[p]  = !empty[p] && ((req_mask[p] & ~won[p]) == '0);
      drop[p] = !empty[p] && (req_mask[p] == '0);
    end
  end

  // NOTE: FIFO storage is left unreset on purpose; the pointers alone decide
  // which entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++)
      if (push[p]) mem[p][wr_ptr[p][WIDTH-1:0]] <= bus.in_data[p*DATASIZE +: DATASIZE];
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        pend[p]   <= '0;
        rr_ptr[p] <= '0;
      end
      pend_load      <= '1;
      bus.out_valid  <= '0;
      bus.out_data   <= '0;
      bus.drop_pulse <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p]) begin
          rd_ptr[p]    <= rd_ptr[p] + 1'b1;
          pend_load[p] <= 1'b1;
        end else if (!empty[p]) begin
          pend[p]      <= req_mask[p] & ~won[p];
          pend_load[p] <= 1'b0;
        end
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (grant_any[o]) begin
          bus.out_data[o*DATASIZE +: DATASIZE] <= head[grant_idx[o]];
          bus.out_valid[o] <= 1'b1;
          rr_ptr[o] <= (grant_idx[o] == PW'(NUM_PORTS-1)) ? '0 : grant_idx[o] + 1'b1;
        end else if (bus.out_ready[o]) begin
          bus.out_valid[o] <= 1'b0;
        end
      end
      bus.drop_pulse <= drop;
    end
  end
endmodule

// File: tb/tb_mc_router_xbar.sv
// Self-checking bench: directed scenarios plus randomized traffic scored
// per (source, output) stream against an in-order delivery model.
module tb_mc_router_xbar;
  localparam int NP    = 5;
  localparam int DS    = 30;
  localparam int DEPTH = 4;
  localparam int WIDTH = 2;
  localparam int SEQW  = DS - NP - 3;

  typedef logic [DS-1:0] flit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   seq = 1;

  flit_t expq [NP*NP][$];   // copies owed, keyed by source*NP + output
  flit_t txq  [NP][$];      // flits waiting to be offered on each input
  int    drop_exp [NP];
  int    drop_seen[NP];
  int    deliv    [NP];
  int    rr_src[$];
  int    rr_cyc[$];
  logic [NP-1:0] hold_v = '0;
  flit_t hold_d[NP];

  always #5 clk = ~clk;

  mc_router_xbar_if #(.NUM_PORTS(NP), .DATASIZE(DS)) bus ();

  mc_router_xbar #(.NUM_PORTS(NP), .DATASIZE(DS), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Header: mask | 3-bit source | unique sequence number.
  function automatic flit_t mk(input logic [NP-1:0] m, input int src);
    logic [2:0] s;
    s = src[2:0];
    seq++;
    return {m, s, seq[SEQW-1:0]};
  endfunction

  function automatic int pending();
    int t = 0;
    for (int i = 0; i < NP*NP; i++) t += expq[i].size();
    return t;
  endfunction

  // Monitor: handshakes are settled at the falling edge and commit on the next rising edge.
  always @(negedge clk) begin
    flit_t f, d, e;
    logic [NP-1:0] m;
    int src;
    cyc++;
    if (rst) begin
      for (int i = 0; i < NP*NP; i++) expq[i].delete();
      for (int p = 0; p < NP; p++) begin
        drop_exp[p] = 0; drop_seen[p] = 0; deliv[p] = 0;
      end
      hold_v = '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (bus.in_valid[p] && bus.in_ready[p]) begin
          f = bus.in_data[p*DS +: DS];
          m = f[DS-1 -: NP];
          if (m == '0) drop_exp[p]++;
          for (int o = 0; o < NP; o++) if (m[o]) expq[p*NP+o].push_back(f);
        end
        if (bus.drop_pulse[p]) drop_seen[p]++;
      end
      for (int o = 0; o < NP; o++) begin
        d = bus.out_data[o*DS +: DS];
        if (hold_v[o]) check($sformatf("hold_out%0d", o), {bus.out_valid[o], d}, {1'b1, hold_d[o]});
        if (bus.out_valid[o] && bus.out_ready[o]) begin
          src = int'(d[DS-NP-1 -: 3]);
          if (src < NP && expq[src*NP+o].size() > 0) e = expq[src*NP+o].pop_front();
          else e = '0;
          check($sformatf("deliver_out%0d", o), d, e);
          if (src < NP) deliv[src]++;
          if (o == 2) begin rr_src.push_back(src); rr_cyc.push_back(cyc); end
        end
        hold_v[o] = bus.out_valid[o] && !bus.out_ready[o];
        hold_d[o] = d;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Offer queued flits until all are accepted; ends on the acceptance edge of the last one.
  task automatic stream(input bit rand_mode, input int budget);
    int n = 0;
    int left;
    forever begin
      left = 0;
      for (int p = 0; p < NP; p++) left += txq[p].size();
      if (left == 0 || n >= budget) break;
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) begin
        bus.in_valid[p] = (txq[p].size() > 0) && (!rand_mode || $urandom_range(0, 3) != 0);
        if (bus.in_valid[p]) bus.in_data[p*DS +: DS] = txq[p][0];
      end
      if (rand_mode)
        for (int o = 0; o < NP; o++) bus.out_ready[o] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int p = 0; p < NP; p++)
        if (bus.in_valid[p] && bus.in_ready[p]) void'(txq[p].pop_front());
      n++;
    end
    check("stream_left", left, 0);
    for (int p = 0; p < NP; p++) txq[p].delete();
    @(posedge clk); #1;
    bus.in_valid = '0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    @(posedge clk); #1;
    bus.out_ready = '1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (pending() == 0 && bus.out_valid == '0) break;
    end
    check("drain_left", pending(), 0);
  endtask

  initial begin
    flit_t f1, f2;
    int rr_exp[3] = '{0, 1, 3};
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 5'b11111);
    check("rst_drop", bus.drop_pulse, 0);
    check("rst_out_data", bus.out_data, 0);

    // Unicast, one-cycle latency
    f1 = 30'h0400_1234;
    txq[0].push_back(f1);
    stream(0, 20);
    @(posedge clk);
    @(negedge clk);
    check("uni_valid", bus.out_valid, 5'b00010);
    check("uni_data", bus.out_data[1*DS +: DS], f1);
    drain(20);

    // Multicast with a busy output: in1 owns out4 first, in2 forks to 0/2/4
    do_reset();
    bus.out_ready = 5'b01111;
    f1 = mk(5'b10000, 1);
    f2 = mk(5'b10101, 2);
    txq[1].push_back(f1);
    txq[2].push_back(f2);
    stream(0, 20);
    @(posedge clk);
    @(negedge clk);
    check("mc_valid", bus.out_valid, 5'b10101);
    check("mc_out4", bus.out_data[4*DS +: DS], f1);
    check("mc_out0", bus.out_data[0*DS +: DS], f2);
    check("mc_in_ready2", bus.in_ready[2], 1'b1);
    repeat (2) @(posedge clk);
    drain(20);
    check("mc_copies", deliv[2], 3);
    check("mc_uni", deliv[1], 1);

    // Round-robin among inputs 0,1,3 towards out2
    do_reset();
    rr_src.delete();
    rr_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      txq[0].push_back(mk(5'b00100, 0));
      txq[1].push_back(mk(5'b00100, 1));
      txq[3].push_back(mk(5'b00100, 3));
    end
    stream(0, 40);
    drain(40);
    check("rr_count", rr_src.size(), 12);
    for (int i = 0; i < rr_src.size() && i < 12; i++)
      check($sformatf("rr_order%0d", i), rr_src[i], rr_exp[i % 3]);
    if (rr_src.size() >= 12) check("rr_span", rr_cyc[11] - rr_cyc[0], 11);

    // FIFO full behind a stalled output
    do_reset();
    bus.out_ready = 5'b11110;
    f1 = mk(5'b00001, 4);
    txq[4].push_back(f1);
    for (int i = 0; i < 4; i++) txq[4].push_back(mk(5'b00001, 4));
    stream(0, 20);
    @(negedge clk);
    check("full_in_ready4", bus.in_ready[4], 1'b0);
    check("full_out_valid0", bus.out_valid[0], 1'b1);
    check("full_out_data0", bus.out_data[0*DS +: DS], f1);
    drain(40);
    check("full_deliv", deliv[4], 5);

    // Zero mask is dropped, next flit still delivered
    do_reset();
    txq[3].push_back(mk(5'b00000, 3));
    txq[3].push_back(mk(5'b00100, 3));
    stream(0, 20);
    drain(20);
    repeat (3) @(negedge clk);
    check("zero_drop3", drop_seen[3], 1);
    check("zero_deliv3", deliv[3], 1);

    // Reset mid-operation discards buffered and in-flight flits
    do_reset();
    bus.out_ready = 5'b11101;
    for (int i = 0; i < 4; i++) txq[0].push_back(mk(5'b00010, 0));
    stream(0, 20);
    @(negedge clk);
    check("mid_busy", bus.out_valid[1], 1'b1);
    do_reset();
    @(negedge clk);
    check("mid_out_valid", bus.out_valid, 0);
    check("mid_in_ready", bus.in_ready, 5'b11111);
    @(posedge clk); #1;
    bus.out_ready = '1;
    repeat (6) begin
      @(negedge clk);
      check("mid_no_stale", bus.out_valid, 0);
    end
    txq[0].push_back(mk(5'b00010, 0));
    stream(0, 20);
    drain(20);
    check("mid_fresh", deliv[0], 1);

    // Randomized traffic with random downstream backpressure
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int p;
      logic [NP-1:0] m;
      p = $urandom_range(0, NP-1);
      m = ($urandom_range(0, 9) == 0) ? '0 : NP'($urandom_range(1, (1 << NP) - 1));
      txq[p].push_back(mk(m, p));
    end
    stream(1, 4000);
    drain(400);
    repeat (3) @(negedge clk);
    for (int p = 0; p < NP; p++)
      check($sformatf("rand_drop%0d", p), drop_seen[p], drop_exp[p]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
